// File: rtl/prog_loader_pkg.sv
// Shared constants for the boot-time program loader: FSM state codes,
// the default frame start byte and the word lane geometry.
package prog_loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE = 3'd0;
    localparam state_t LEN0 = 3'd1;
    localparam state_t LEN1 = 3'd2;
    localparam state_t DATA = 3'd3;
    localparam state_t CSUM = 3'd4;
    localparam state_t DONE = 3'd5;
    localparam state_t ERR  = 3'd6;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

    localparam int         LANES     = 4;
    localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Assembles accepted bytes into little-endian 32-bit words. The finished word
// and its strobe are presented combinationally alongside the lane-3 byte.
module byte_packer
    import prog_loader_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        clr,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  lane;
    logic [23:0] low;

    // NOTE: state is written with <= only, so every register samples the
    // pre-edge value of every other register regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            lane <= '0;
            low  <= '0;
        end else if (in_valid) begin
            lane <= lane + 2'd1;
            case (lane)
                2'd0:    low[7:0]   <= in_byte;
                2'd1:    low[15:8]  <= in_byte;
                2'd2:    low[23:16] <= in_byte;
                default: ;
            endcase
        end
    end

    assign word       = {in_byte, low};
    assign word_valid = in_valid && (lane == LAST_LANE);

endmodule

// File: rtl/prog_loader.sv
// Frame parser that writes a checksummed program image into instruction
// memory and holds the CPU in reset until the image has been verified.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0] MAGIC  = MAGIC_DEFAULT,
    parameter int         ADDR_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              arm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    state_t            state;
    logic [15:0]       cnt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_next;
    logic [7:0]        csum;
    logic              hs;
    logic [31:0]       word;
    logic              word_valid;

    assign byte_ready = (state != DONE) && (state != ERR);
    assign hs         = byte_valid && byte_ready;
    assign idx_next   = idx + ADDR_W'(1);

    byte_packer u_packer (
        .CLK        (CLK),
        .RST        (RST),
        .clr        (hs && (state == LEN1)),
        .in_byte    (byte_data),
        .in_valid   (hs && (state == DATA)),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            csum      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: if (hs && (byte_data == MAGIC)) state <= LEN0;
                LEN0: if (hs) begin
                    cnt[7:0] <= byte_data;
                    state    <= LEN1;
                end
                // Checksum clears even for an empty frame so CSUM compares against 0.
                LEN1: if (hs) begin
                    cnt[15:8] <= byte_data;
                    idx       <= '0;
                    csum      <= '0;
                    state     <= ({byte_data, cnt[7:0]} == 16'd0) ? CSUM : DATA;
                end
                DATA: if (hs) begin
                    csum <= csum + byte_data;
                    if (word_valid) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= idx;
                        mem_wdata <= word;
                        idx       <= idx_next;
                        if (32'(idx_next) == 32'(cnt)) state <= CSUM;
                    end
                end
                CSUM: if (hs) state <= (byte_data == csum) ? DONE : ERR;
                DONE, ERR: if (arm) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Status flags decode straight from the state register, so they move
    // in the cycle after the CSUM handshake or the arm pulse.
    assign done     = (state == DONE);
    assign error    = (state == ERR);
    assign cpu_hold = (state != DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a frame-level scoreboard predicts every
// memory write and the status flags; directed frames pin it with literals.
module tb_prog_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  byte_data = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        arm = 1'b0;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    always #5 CLK = ~CLK;

    prog_loader dut (
        .CLK        (CLK),
        .RST        (RST),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .arm        (arm),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          stamp;
    } wr_t;

    wr_t         exp_q[$];
    int          log_addr[$];
    logic [31:0] log_data[$];
    logic [31:0] fw[$];

    int          checks = 0;
    int          errors = 0;
    int          ncyc = 0;
    bit          cmp_en = 1'b0;
    bit          exp_done = 1'b0;
    bit          exp_err = 1'b0;
    bit          rand_arm_en = 1'b0;
    logic [15:0] last_addr = '0;
    logic [31:0] last_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the scoreboard, on the falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (cmp_en) begin
                ncyc++;
                check("byte_ready", 32'(byte_ready), 32'(!(exp_done || exp_err)));
                check("done", 32'(done), 32'(exp_done));
                check("error", 32'(error), 32'(exp_err));
                check("cpu_hold", 32'(cpu_hold), 32'(!exp_done));
                if (mem_we) begin
                    log_addr.push_back(int'(mem_addr));
                    log_data.push_back(mem_wdata);
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 32'(mem_we), 32'd0);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        check("write_cycle", 32'(ncyc), 32'(e.stamp));
                        check("mem_addr", 32'(mem_addr), 32'(e.addr));
                        check("mem_wdata", mem_wdata, e.data);
                        last_addr = 16'(e.addr);
                        last_data = e.data;
                    end
                end else begin
                    if (exp_q.size() > 0 && exp_q[0].stamp <= ncyc) begin
                        check("missing_write", 32'(mem_we), 32'd1);
                        void'(exp_q.pop_front());
                    end
                    check("mem_addr_hold", 32'(mem_addr), 32'(last_addr));
                    check("mem_wdata_hold", mem_wdata, last_data);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // Tasks start just after a rising edge and return just after the rising
    // edge that consumed the byte.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            @(negedge CLK);
            byte_valid = 1'b0;
            @(posedge CLK);
        end
        @(negedge CLK);
        byte_data  = b;
        byte_valid = 1'b1;
        arm        = rand_arm_en && ($urandom_range(7, 0) == 0);
        t = 0;
        while (!byte_ready && t < 50) begin
            @(posedge CLK);
            @(negedge CLK);
            t++;
        end
        if (!byte_ready) check("ready_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        #1 arm = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            byte_valid = 1'b0;
            @(posedge CLK);
        end
    endtask

    task automatic arm_pulse(input bit with_byte, input logic [7:0] b);
        @(negedge CLK);
        arm        = 1'b1;
        byte_valid = with_byte;
        byte_data  = b;
        check("ready_at_arm", 32'(byte_ready), 32'd0);
        @(posedge CLK);
        exp_done = 1'b0;
        exp_err  = 1'b0;
        #1 arm = 1'b0;
    endtask

    // Sends a frame built from fw[0 .. cnt-1]; csum_ofs != 0 corrupts CSUM.
    task automatic send_frame(input int cnt, input logic [7:0] csum_ofs,
                              input bit skip_magic, input int maxgap);
        logic [15:0] c;
        logic [7:0]  sum;
        logic [7:0]  b;
        logic [31:0] w;
        c   = 16'(cnt);
        sum = '0;
        if (!skip_magic) send_byte(8'hA5, $urandom_range(maxgap, 0));
        send_byte(c[7:0], $urandom_range(maxgap, 0));
        send_byte(c[15:8], $urandom_range(maxgap, 0));
        for (int k = 0; k < 4 * cnt; k++) begin
            w   = fw[k / 4];
            b   = w[8 * (k % 4) +: 8];
            sum = sum + b;
            send_byte(b, $urandom_range(maxgap, 0));
            if (k % 4 == 3) exp_q.push_back('{k / 4, w, ncyc + 1});
        end
        send_byte(sum + csum_ofs, $urandom_range(maxgap, 0));
        exp_done = (csum_ofs == 8'd0);
        exp_err  = (csum_ofs != 8'd0);
    endtask

    task automatic rand_words(input int n);
        fw.delete();
        for (int i = 0; i < n; i++) fw.push_back($urandom);
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        check("rst_byte_ready", 32'(byte_ready), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        cmp_en = 1'b1;
        @(posedge CLK);

        // Good three-word frame, back-to-back bytes.
        fw = '{32'h000A0006, 32'h00032006, 32'h00004006};
        log_addr.delete(); log_data.delete();
        send_frame(3, 8'h00, 1'b0, 0);
        idle(2);
        check("t1_nwrites", 32'(log_data.size()), 32'd3);
        for (int i = 0; i < 3 && i < log_data.size(); i++)
            check("t1_addr", 32'(log_addr[i]), 32'(i));
        if (log_data.size() == 3) begin
            check("t1_w0", log_data[0], 32'h000A0006);
            check("t1_w1", log_data[1], 32'h00032006);
            check("t1_w2", log_data[2], 32'h00004006);
        end
        check("t1_done", 32'(done), 32'd1);
        check("t1_cpu_hold", 32'(cpu_hold), 32'd0);
        arm_pulse(1'b0, 8'h00);

        // Same frame, checksum 80 instead of 7F.
        log_addr.delete(); log_data.delete();
        send_frame(3, 8'h01, 1'b0, 1);
        idle(2);
        check("t2_nwrites", 32'(log_data.size()), 32'd3);
        check("t2_error", 32'(error), 32'd1);
        check("t2_cpu_hold", 32'(cpu_hold), 32'd1);
        check("t2_done", 32'(done), 32'd0);
        arm_pulse(1'b0, 8'h00);
        idle(1);
        check("t2_error_cleared", 32'(error), 32'd0);

        // Garbage ahead of a one-word frame.
        send_byte(8'h00, 0);
        send_byte(8'hFF, 1);
        send_byte(8'h5A, 0);
        fw = '{32'h44332211};
        log_addr.delete(); log_data.delete();
        send_frame(1, 8'h00, 1'b0, 0);
        idle(1);
        check("t3_nwrites", 32'(log_data.size()), 32'd1);
        if (log_data.size() == 1) begin
            check("t3_addr", 32'(log_addr[0]), 32'd0);
            check("t3_word", log_data[0], 32'h44332211);
        end
        check("t3_done", 32'(done), 32'd1);
        arm_pulse(1'b0, 8'h00);

        // Empty frame, then bytes offered in DONE, then arm with a byte present.
        fw.delete();
        log_addr.delete(); log_data.delete();
        send_frame(0, 8'h00, 1'b0, 0);
        @(negedge CLK);
        byte_data  = 8'h5A;
        byte_valid = 1'b1;
        repeat (3) @(posedge CLK);
        check("t4_nwrites", 32'(log_data.size()), 32'd0);
        check("t4_done", 32'(done), 32'd1);
        arm_pulse(1'b1, 8'hA5);
        send_byte(8'hA5, 0);
        rand_words(2);
        send_frame(2, 8'h00, 1'b1, 1);
        idle(1);
        check("t4_reload_nwrites", 32'(log_data.size()), 32'd2);
        arm_pulse(1'b0, 8'h00);

        // Reset after the second payload byte.
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        @(negedge CLK);
        RST        = 1'b1;
        byte_valid = 1'b0;
        @(posedge CLK);
        exp_done = 1'b0; exp_err = 1'b0;
        last_addr = '0; last_data = '0;
        log_addr.delete(); log_data.delete();
        @(negedge CLK);
        RST = 1'b0;
        check("t5_cpu_hold", 32'(cpu_hold), 32'd1);
        check("t5_ready", 32'(byte_ready), 32'd1);
        @(posedge CLK);
        rand_words(2);
        send_frame(2, 8'h00, 1'b0, 1);
        idle(1);
        check("t5_nwrites", 32'(log_data.size()), 32'd2);
        if (log_data.size() > 0) check("t5_first_addr", 32'(log_addr[0]), 32'd0);
        arm_pulse(1'b0, 8'h00);

        // Count with a nonzero high byte.
        rand_words(256);
        send_frame(256, 8'h00, 1'b0, 0);
        idle(1);
        arm_pulse(1'b0, 8'h00);

        // Randomised frames with garbage, gaps, stray arm pulses and bad sums.
        rand_arm_en = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int          ng;
            int          cnt;
            logic [7:0]  g;
            logic [7:0]  ofs;
            ng = $urandom_range(3, 0);
            for (int i = 0; i < ng; i++) begin
                g = 8'($urandom_range(255, 0));
                if (g == 8'hA5) g = 8'h00;
                send_byte(g, $urandom_range(2, 0));
            end
            cnt = $urandom_range(6, 0);
            rand_words(cnt);
            ofs = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            send_frame(cnt, ofs, 1'b0, 2);
            idle($urandom_range(3, 0));
            arm_pulse(1'($urandom_range(1, 0)), 8'($urandom_range(255, 0)));
        end
        rand_arm_en = 1'b0;

        idle(3);
        cmp_en = 1'b0;
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
